// File: rtl/tcp_msg_ptr_poller_ctrl.sv
// Control FSM for the TCP message-pointer poller: pops one flow, fetches its request record
// and app pointers, then either sends a descriptor (clearing the active bit) or requeues it.
module tcp_msg_ptr_poller_ctrl #(
   parameter int POLL_GAP   = 0,
   parameter int POLL_GAP_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic msg_req_q_poll_ctrl_empty,
   output logic poll_ctrl_msg_req_q_rd_req,
   input  logic msg_req_q_poll_ctrl_full,
   output logic poll_ctrl_msg_req_q_wr_req,
   output logic poll_ctrl_msg_req_mem_rd_req_val,
   input  logic msg_req_mem_poll_ctrl_rd_req_rdy,
   input  logic msg_req_mem_poll_ctrl_rd_resp_val,
   output logic poll_ctrl_msg_req_mem_rd_resp_rdy,
   output logic app_base_ptr_rd_req_val,
   input  logic base_ptr_app_rd_req_rdy,
   input  logic base_ptr_app_rd_resp_val,
   output logic app_base_ptr_rd_resp_rdy,
   output logic app_end_ptr_rd_req_val,
   input  logic end_ptr_app_rd_req_rdy,
   input  logic end_ptr_app_rd_resp_val,
   output logic app_end_ptr_rd_resp_rdy,
   output logic poller_msg_dst_val,
   input  logic poller_msg_dst_rdy,
   output logic poll_active_bitvec_clear_req_val,
   output logic ctrl_data_store_flowid,
   output logic ctrl_data_store_req_data,
   output logic ctrl_data_store_ptrs,
   input  logic data_ctrl_msg_satis,
   output logic poll_ctrl_busy
);

   typedef enum logic [2:0] {
      IDLE, MEM_RESP, PTR_REQ, PTR_RESP, CHECK, SEND, REQUEUE
   } state_e;

   state_e                state_q, state_d;
   logic [POLL_GAP_W-1:0] gap_q, gap_d;

   logic ptrs_both_rdy, ptrs_both_val;
   assign ptrs_both_rdy = base_ptr_app_rd_req_rdy & end_ptr_app_rd_req_rdy;
   assign ptrs_both_val = base_ptr_app_rd_resp_val & end_ptr_app_rd_resp_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (gap_q != '0)
               gap_d = gap_q - POLL_GAP_W'(1);
            else if (!msg_req_q_poll_ctrl_empty && msg_req_mem_poll_ctrl_rd_req_rdy)
               state_d = MEM_RESP;
         end
         MEM_RESP: if (msg_req_mem_poll_ctrl_rd_resp_val) state_d = PTR_REQ;
         // Pointer reads issue and complete as a pair so the datap sees a coherent snapshot
         PTR_REQ:  if (ptrs_both_rdy) state_d = PTR_RESP;
         PTR_RESP: if (ptrs_both_val) state_d = CHECK;
         CHECK:    state_d = data_ctrl_msg_satis ? SEND : REQUEUE;
         SEND:     if (poller_msg_dst_rdy) state_d = IDLE;
         REQUEUE: begin
            if (!msg_req_q_poll_ctrl_full) begin
               state_d = IDLE;
               gap_d   = POLL_GAP_W'(POLL_GAP);
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      poll_ctrl_msg_req_q_rd_req        = 1'b0;
      poll_ctrl_msg_req_q_wr_req        = 1'b0;
      poll_ctrl_msg_req_mem_rd_req_val  = 1'b0;
      poll_ctrl_msg_req_mem_rd_resp_rdy = 1'b0;
      app_base_ptr_rd_req_val           = 1'b0;
      app_base_ptr_rd_resp_rdy          = 1'b0;
      app_end_ptr_rd_req_val            = 1'b0;
      app_end_ptr_rd_resp_rdy           = 1'b0;
      poller_msg_dst_val                = 1'b0;
      poll_active_bitvec_clear_req_val  = 1'b0;
      ctrl_data_store_flowid            = 1'b0;
      ctrl_data_store_req_data          = 1'b0;
      ctrl_data_store_ptrs              = 1'b0;
      poll_ctrl_busy                    = 1'b0;
      if (!rst) begin
         poll_ctrl_busy = (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (gap_q == '0 && !msg_req_q_poll_ctrl_empty && msg_req_mem_poll_ctrl_rd_req_rdy) begin
                  poll_ctrl_msg_req_q_rd_req       = 1'b1;
                  poll_ctrl_msg_req_mem_rd_req_val = 1'b1;
                  ctrl_data_store_flowid           = 1'b1;
               end
            end
            MEM_RESP: begin
               poll_ctrl_msg_req_mem_rd_resp_rdy = 1'b1;
               ctrl_data_store_req_data          = msg_req_mem_poll_ctrl_rd_resp_val;
            end
            PTR_REQ: begin
               app_base_ptr_rd_req_val = 1'b1;
               app_end_ptr_rd_req_val  = 1'b1;
            end
            PTR_RESP: begin
               app_base_ptr_rd_resp_rdy = ptrs_both_val;
               app_end_ptr_rd_resp_rdy  = ptrs_both_val;
               ctrl_data_store_ptrs     = ptrs_both_val;
            end
            SEND: begin
               poller_msg_dst_val               = 1'b1;
               poll_active_bitvec_clear_req_val = poller_msg_dst_rdy;
            end
            REQUEUE: poll_ctrl_msg_req_q_wr_req = !msg_req_q_poll_ctrl_full;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tcp_msg_ptr_poller_ctrl.sv
// Directed bench for the poller control FSM; a scoreboard queue holds the expected outcome
// ("S" send / "R" requeue) of each popped flow and a negedge monitor retires them.
module tb_tcp_msg_ptr_poller_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic empty, full, mem_rdy, mem_rvl, b_rdy, b_rvl, e_rdy, e_rvl, dst_rdy, satis;
   logic rd_req, wr_req, mem_req_val, mem_resp_rdy, b_req_val, b_resp_rdy, e_req_val, e_resp_rdy;
   logic dst_val, clr, st_fid, st_req, st_ptrs, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int clr_cnt = 0;
   int ptrs_cnt = 0;
   byte exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tcp_msg_ptr_poller_ctrl #(.POLL_GAP(3), .POLL_GAP_W(4)) dut (
      .clk                               (clk),
      .rst                               (rst),
      .msg_req_q_poll_ctrl_empty         (empty),
      .poll_ctrl_msg_req_q_rd_req        (rd_req),
      .msg_req_q_poll_ctrl_full          (full),
      .poll_ctrl_msg_req_q_wr_req        (wr_req),
      .poll_ctrl_msg_req_mem_rd_req_val  (mem_req_val),
      .msg_req_mem_poll_ctrl_rd_req_rdy  (mem_rdy),
      .msg_req_mem_poll_ctrl_rd_resp_val (mem_rvl),
      .poll_ctrl_msg_req_mem_rd_resp_rdy (mem_resp_rdy),
      .app_base_ptr_rd_req_val           (b_req_val),
      .base_ptr_app_rd_req_rdy           (b_rdy),
      .base_ptr_app_rd_resp_val          (b_rvl),
      .app_base_ptr_rd_resp_rdy          (b_resp_rdy),
      .app_end_ptr_rd_req_val            (e_req_val),
      .end_ptr_app_rd_req_rdy            (e_rdy),
      .end_ptr_app_rd_resp_val           (e_rvl),
      .app_end_ptr_rd_resp_rdy           (e_resp_rdy),
      .poller_msg_dst_val                (dst_val),
      .poller_msg_dst_rdy                (dst_rdy),
      .poll_active_bitvec_clear_req_val  (clr),
      .ctrl_data_store_flowid            (st_fid),
      .ctrl_data_store_req_data          (st_req),
      .ctrl_data_store_ptrs              (st_ptrs),
      .data_ctrl_msg_satis               (satis),
      .poll_ctrl_busy                    (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] all_outs();
      return {rd_req, wr_req, mem_req_val, mem_resp_rdy, b_req_val, b_resp_rdy, e_req_val,
              e_resp_rdy, dst_val, clr, st_fid, st_req, st_ptrs, busy, 2'b00};
   endfunction

   // Scoreboard retire: a handshake on the dst port or a requeue push consumes one entry.
   always @(negedge clk) begin
      if (clr) clr_cnt++;
      if (st_ptrs) ptrs_cnt++;
      if (!rst) chk("clr_only_on_hs", clr, dst_val & dst_rdy);
      if (dst_val && dst_rdy) begin
         if (exp_q.size() == 0) chk("sb_unexpected_send", 1, 0);
         else chk("sb_send", exp_q.pop_front(), "S");
      end
      if (wr_req) begin
         if (exp_q.size() == 0) chk("sb_unexpected_requeue", 1, 0);
         else chk("sb_requeue", exp_q.pop_front(), "R");
      end
   end

   // Zero-wait walk from the IDLE pop through to the CHECK state (caller sits in IDLE, gap 0).
   task automatic flow_to_check(input logic sat);
      empty = 1'b0; mem_rdy = 1'b1; #1;
      chk("pop", {rd_req, mem_req_val, st_fid}, 3'b111);
      tick();
      empty = 1'b1; mem_rdy = 1'b0; mem_rvl = 1'b1; #1;
      chk("mem_resp", {mem_resp_rdy, st_req, busy}, 3'b111);
      tick();
      mem_rvl = 1'b0; b_rdy = 1'b1; e_rdy = 1'b1; #1;
      chk("ptr_req", {b_req_val, e_req_val}, 2'b11);
      tick();
      b_rdy = 1'b0; e_rdy = 1'b0; b_rvl = 1'b1; e_rvl = 1'b1; #1;
      chk("ptr_resp", {b_resp_rdy, e_resp_rdy, st_ptrs}, 3'b111);
      tick();
      b_rvl = 1'b0; e_rvl = 1'b0; satis = sat; #1;
      chk("check_state", {busy, dst_val, wr_req}, 3'b100);
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      empty = 1'b0; full = 1'b0; mem_rdy = 1'b1; mem_rvl = 1'b1; b_rdy = 1'b1; b_rvl = 1'b1;
      e_rdy = 1'b1; e_rvl = 1'b1; dst_rdy = 1'b1; satis = 1'b1;
      #2;
      chk("outs_zero_in_rst", all_outs(), 16'h0);
      tick(); tick();
      rst = 1'b0;
      empty = 1'b1; mem_rdy = 1'b0; mem_rvl = 1'b0; b_rdy = 1'b0; b_rvl = 1'b0;
      e_rdy = 1'b0; e_rvl = 1'b0; dst_rdy = 1'b0; satis = 1'b0; #1;
      chk("idle_after_rst", {busy, rd_req}, 2'b00);

      // 1: reset while SEND is stalled; the flow is dropped
      flow_to_check(1'b1);
      tick();
      #1 chk("send_val_stalled", dst_val, 1'b1);
      tick();
      rst = 1'b1; dst_rdy = 1'b1; #1;
      chk("rst_mid_send_zero", all_outs(), 16'h0);
      tick();
      rst = 1'b0; #1;
      chk("post_rst_idle", {busy, dst_val, clr}, 3'b000);
      dst_rdy = 1'b0;
      tick();

      // 2: satisfied flow, 6 cycles pop-to-IDLE
      exp_q.push_back("S");
      t0 = cyc;
      flow_to_check(1'b1);
      tick();
      satis = 1'b0; dst_rdy = 1'b1; #1;
      chk("send_hs", {dst_val, clr}, 2'b11);
      tick();
      dst_rdy = 1'b0; #1;
      chk("back_idle", busy, 1'b0);
      chk("latency6", cyc - t0, 6);

      // 3: unsatisfied flow requeues, then exactly 3 gap cycles
      exp_q.push_back("R");
      flow_to_check(1'b0);
      tick();
      #1 chk("requeue_push", {wr_req, busy}, 2'b11);
      tick();
      empty = 1'b0; mem_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("gap_no_pop", {rd_req, busy}, 2'b00);
         tick();
      end
      #1 chk("pop_after_gap", {rd_req, mem_req_val}, 2'b11);
      exp_q.push_back("R");
      tick();

      // 4: staggered pointer readiness and responses
      empty = 1'b1; mem_rdy = 1'b0; mem_rvl = 1'b1;
      tick();
      mem_rvl = 1'b0; b_rdy = 1'b0; e_rdy = 1'b1; #1;
      chk("ptr_hold_a", {b_req_val, e_req_val}, 2'b11);
      tick();
      b_rdy = 1'b1; e_rdy = 1'b0; #1;
      chk("ptr_hold_b", {b_req_val, e_req_val}, 2'b11);
      tick();
      e_rdy = 1'b1;
      tick();
      b_rdy = 1'b0; e_rdy = 1'b0; b_rvl = 1'b1;
      ptrs_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         #1 chk("lone_base_held", {b_resp_rdy, e_resp_rdy, st_ptrs, busy}, 4'b0001);
         tick();
      end
      e_rvl = 1'b1; #1;
      chk("both_resp", {b_resp_rdy, e_resp_rdy, st_ptrs}, 3'b111);
      tick();
      b_rvl = 1'b0; e_rvl = 1'b0; satis = 1'b0; #1;
      chk("store_ptrs_once", ptrs_cnt, 1);

      // 5: requeue blocked by a full queue for 4 cycles
      tick();
      full = 1'b1; empty = 1'b0; mem_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("full_stall", {wr_req, rd_req, busy}, 3'b001);
         tick();
      end
      full = 1'b0; #1;
      chk("full_drop_push", {wr_req, rd_req}, 2'b10);
      tick();
      for (int i = 0; i < 3; i++) tick();

      // 6: sink back-pressure for 10 cycles
      exp_q.push_back("S");
      flow_to_check(1'b1);
      tick();
      clr_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #1 chk("dst_held", {dst_val, clr}, 2'b10);
         tick();
      end
      dst_rdy = 1'b1; #1;
      chk("dst_hs_11th", {dst_val, clr}, 2'b11);
      tick();
      dst_rdy = 1'b0; satis = 1'b0; #1;
      chk("idle_end", {busy, rd_req}, 2'b00);
      tick(); tick();
      chk("one_clear_pulse", clr_cnt, 1);
      chk("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
